// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive and transmit paths.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } ps2_rx_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, saturating glitch filter and falling-edge detector for one PS/2 line.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic fall
);

    logic       sync_1;
    logic       sync_2;
    logic       filt;
    logic [3:0] cnt;

    // Two-flop synchronizer; idle PS/2 lines are high, so reset there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= line_in;
            sync_2 <= sync_1;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples;
    // fall pulses in the same cycle the filtered level goes 1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_2 != filt) begin
                if (cnt == 4'(FILTER_LEN - 1)) begin
                    filt <= sync_2;
                    cnt  <= '0;
                    fall <= filt;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host receiver: frame deframing, parity/stop checks, E0/F0 key folding.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       timeout_err_o,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_release_o,
    output logic       key_valid_o,
    output logic       busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          tick;
    logic          data_s1;
    logic          data_s2;
    ps2_rx_state_t state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [10:0]   shift, shift_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]    byte_n;
    logic          bv_n, pe_n, fe_n, to_n;
    logic          ext, brk;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .fall    (tick)
    );

    // Data line only needs synchronizing; it is sampled on clock ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    // Frame FSM next-state and datapath; tmo counts cycles since the last tick.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tmo_n     = tmo;
        byte_n    = byte_o;
        bv_n      = 1'b0;
        pe_n      = 1'b0;
        fe_n      = 1'b0;
        to_n      = 1'b0;
        if (!ena) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            tmo_n     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && !data_s2) begin
                        shift_n   = {data_s2, shift[10:1]};
                        bit_cnt_n = 4'd1;
                        tmo_n     = TW'(1);
                        state_n   = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (tick) begin
                        shift_n   = {data_s2, shift[10:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                        tmo_n     = TW'(1);
                        if (bit_cnt == 4'(PS2_FRAME_BITS - 1))
                            state_n = ST_CHECK;
                    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        to_n      = 1'b1;
                        state_n   = ST_IDLE;
                        bit_cnt_n = '0;
                        tmo_n     = '0;
                    end else begin
                        tmo_n = tmo + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_n   = ST_IDLE;
                    bit_cnt_n = '0;
                    tmo_n     = '0;
                    // shift: [0] start, [8:1] data, [9] parity, [10] stop
                    if (shift[0] || !shift[10]) begin
                        fe_n = 1'b1;
                    end else if (!odd_parity_ok(shift[9:1])) begin
                        pe_n = 1'b1;
                    end else begin
                        bv_n   = 1'b1;
                        byte_n = shift[8:1];
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Frame datapath and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            shift         <= '0;
            tmo           <= '0;
            byte_o        <= '0;
            byte_valid_o  <= 1'b0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            bit_cnt       <= bit_cnt_n;
            shift         <= shift_n;
            tmo           <= tmo_n;
            byte_o        <= byte_n;
            byte_valid_o  <= bv_n;
            parity_err_o  <= pe_n;
            frame_err_o   <= fe_n;
            timeout_err_o <= to_n;
        end
    end

    // Key decoder: prefixes accumulate until a plain code closes the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext           <= 1'b0;
            brk           <= 1'b0;
            key_code_o    <= '0;
            key_ext_o     <= 1'b0;
            key_release_o <= 1'b0;
            key_valid_o   <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            if (!ena) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid_o) begin
                if (byte_o == PS2_PREFIX_EXT) begin
                    ext <= 1'b1;
                end else if (byte_o == PS2_PREFIX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    key_code_o    <= byte_o;
                    key_ext_o     <= ext;
                    key_release_o <= brk;
                    key_valid_o   <= 1'b1;
                    ext           <= 1'b0;
                    brk           <= 1'b0;
                end
            end else if (parity_err_o || frame_err_o || timeout_err_o) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule
